pattern_sequencer: RTL and testbench

- Generates the ROM read address (address_b) for the pattern ROM feeding LEDR, plus the current sequence number for the HEX display path.
- Sits between the throttle (slow_clk) and the debounced seq push-buttons upstream, and the dual-port pattern ROM downstream.
- Runs entirely on clk_50. slow_clk is treated as a data signal and edge-detected, never used as a clock.
- Each sequence occupies SEQ_LEN consecutive ROM words. The step advances once per slow_clk period.

---
 rtl/kros_pkg.sv | 8 +
 rtl/pattern_sequencer_edge_sync.sv | 26 ++
 rtl/pattern_sequencer.sv | 88 ++++++++
 tb/tb_pattern_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/kros_pkg.sv
// kros_pkg: shared FSM state type and default widths for the pattern sequencer
package kros_pkg;
    typedef enum logic {ALIGN, RUN} seq_state_t;
    localparam int ADDR_W_DEF  = 10;
    localparam int SEQ_W_DEF   = 6;
    localparam int STEP_W_DEF  = 4;
    localparam int NUM_SEQ_DEF = 64;
endpackage

// File: rtl/pattern_sequencer_edge_sync.sv
// edge_sync: optional DEPTH-flop synchroniser (DEPTH=0 bypasses it) followed by a rising-edge pulse
module edge_sync #(
    parameter int DEPTH = 2
) (
    input  logic clk_50,
    input  logic reset,
    input  logic din,
    output logic pulse
);
    logic lvl, prev;
    generate
        if (DEPTH == 0) begin : g_direct
            assign lvl = din;
        end else begin : g_sync
            logic [DEPTH-1:0] sync;
            always_ff @(posedge clk_50 or posedge reset)
                if (reset) sync <= '0;
                else sync <= (sync << 1) | DEPTH'(din);
            assign lvl = sync[DEPTH-1];
        end
    endgenerate
    always_ff @(posedge clk_50 or posedge reset)
        if (reset) prev <= 1'b0;
        else prev <= lvl;
    assign pulse = lvl & ~prev;
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: pattern ROM address and sequence-number generator driven by slow_clk ticks
// PATTERN_SEQ_BOUNCE_EN selects ping-pong stepping instead of modulo wrap.
module pattern_sequencer
    import kros_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int SEQ_W   = SEQ_W_DEF,
    parameter int NUM_SEQ = NUM_SEQ_DEF,
    parameter int STEP_W  = STEP_W_DEF
) (
    input  logic              clk_50,
    input  logic              reset,
    input  logic              slow_clk,
    input  logic              pb_seq_up,
    input  logic              pb_seq_dn,
    input  logic              run_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [SEQ_W-1:0]  seq_num,
    output logic [STEP_W-1:0] step,
    output logic              wrap_pulse,
    output logic              seq_changed
);
    localparam logic [SEQ_W-1:0]  seq_last  = SEQ_W'(NUM_SEQ - 1);
    localparam logic [STEP_W-1:0] step_last = '1;
    seq_state_t state;
    logic tick, up_ev, dn_ev, btn_ev, wrap_nx;
    logic [SEQ_W-1:0]  seq_nx;
    logic [STEP_W-1:0] step_nx;
    edge_sync #(.DEPTH(2)) u_tick (.clk_50(clk_50), .reset(reset), .din(slow_clk),  .pulse(tick));
    edge_sync #(.DEPTH(0)) u_up   (.clk_50(clk_50), .reset(reset), .din(pb_seq_up), .pulse(up_ev));
    edge_sync #(.DEPTH(0)) u_dn   (.clk_50(clk_50), .reset(reset), .din(pb_seq_dn), .pulse(dn_ev));
    // Coincident up and down edges cancel each other
    assign btn_ev = up_ev ^ dn_ev;
    function automatic logic [ADDR_W-1:0] base(input logic [SEQ_W-1:0] s);
        return ADDR_W'(s) << STEP_W;
    endfunction
    always_comb begin
        seq_nx = up_ev ? (seq_num == seq_last ? '0 : seq_num + 1'b1)
                       : (seq_num == '0 ? seq_last : seq_num - 1'b1);
    end
`ifdef PATTERN_SEQ_BOUNCE_EN
    logic dir_up;
    always_comb begin
        step_nx = dir_up ? (step == step_last ? step - 1'b1 : step + 1'b1)
                         : (step == '0 ? step + 1'b1 : step - 1'b1);
        wrap_nx = !dir_up && step == STEP_W'(1);
    end
`else
    always_comb begin
        step_nx = step + 1'b1;
        wrap_nx = step == step_last;
    end
`endif
    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state       <= ALIGN;
            seq_num     <= '0;
            step        <= '0;
            rom_addr    <= '0;
            wrap_pulse  <= 1'b0;
            seq_changed <= 1'b0;
`ifdef PATTERN_SEQ_BOUNCE_EN
            dir_up      <= 1'b1;
`endif
        end else begin
            wrap_pulse  <= 1'b0;
            seq_changed <= btn_ev;
            if (btn_ev) begin
                seq_num  <= seq_nx;
                step     <= '0;
                rom_addr <= base(seq_nx);
                state    <= ALIGN;
`ifdef PATTERN_SEQ_BOUNCE_EN
                dir_up   <= 1'b1;
`endif
            end else if (tick && state == ALIGN) begin
                state <= RUN;
            end else if (tick && run_en) begin
                step       <= step_nx;
                rom_addr   <= base(seq_num) | ADDR_W'(step_nx);
                wrap_pulse <= wrap_nx;
`ifdef PATTERN_SEQ_BOUNCE_EN
                dir_up     <= dir_up ? step != step_last : step == '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: scoreboard bench; stimulus pushes expected outputs, a monitor pops on every output change
module tb_pattern_sequencer;
    logic clk_50 = 1'b0, reset = 1'b1, slow_clk = 1'b0;
    logic pb_seq_up = 1'b0, pb_seq_dn = 1'b0, run_en = 1'b1;
    logic [9:0] rom_addr;
    logic [5:0] seq_num;
    logic [3:0] step;
    logic wrap_pulse, seq_changed;

    pattern_sequencer dut (
        .clk_50(clk_50), .reset(reset), .slow_clk(slow_clk),
        .pb_seq_up(pb_seq_up), .pb_seq_dn(pb_seq_dn), .run_en(run_en),
        .rom_addr(rom_addr), .seq_num(seq_num), .step(step),
        .wrap_pulse(wrap_pulse), .seq_changed(seq_changed)
    );

    always #5 clk_50 = ~clk_50;

    typedef struct {int addr; int seq; int stp; int wr; int sc; int cyc;} exp_t;
    exp_t q[$];
    int tests = 0, fails = 0, cyc = 0, wrap_cnt = 0;
    int m_seq = 0, m_step = 0;
    bit m_align = 1'b1, m_dir = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: one scoreboard entry per cycle in which the outputs change or a pulse is high
    initial begin
        logic [19:0] prev, cur;
        exp_t e;
        prev = '0;
        forever begin
            @(posedge clk_50);
            cyc++;
            #1;
            cur = {rom_addr, seq_num, step};
            if (reset) prev = cur;
            else if (cur != prev || wrap_pulse || seq_changed) begin
                if (wrap_pulse) wrap_cnt++;
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: addr=%0d seq=%0d step=%0d wrap=%0b chg=%0b, expected no change (cycle %0d)",
                             rom_addr, seq_num, step, wrap_pulse, seq_changed, cyc);
                end else begin
                    e = q.pop_front();
                    chk("sb_rom_addr", int'(rom_addr), e.addr);
                    chk("sb_seq_num", int'(seq_num), e.seq);
                    chk("sb_step", int'(step), e.stp);
                    chk("sb_wrap_pulse", int'(wrap_pulse), e.wr);
                    chk("sb_seq_changed", int'(seq_changed), e.sc);
                    chk("sb_latency_cycle", cyc, e.cyc);
                end
                prev = cur;
            end
        end
    end

    task automatic push(input int s, input int st, input int wr, input int sc, input int c);
        q.push_back('{s * 16 + st, s, st, wr, sc, c});
    endtask

    task automatic model_press(input bit up, input bit dn, input int c);
        if (up ^ dn) begin
            m_seq   = up ? (m_seq + 1) % 64 : (m_seq + 63) % 64;
            m_step  = 0;
            m_align = 1'b1;
            m_dir   = 1'b1;
            push(m_seq, 0, 0, 1, c);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            int k, nstep, wr;
            @(negedge clk_50);
            k = cyc;
            slow_clk = 1'b1;
            if (m_align) m_align = 1'b0;
            else if (run_en) begin
`ifdef PATTERN_SEQ_BOUNCE_EN
                wr = (!m_dir && m_step == 1) ? 1 : 0;
                if (m_dir) begin
                    nstep = (m_step == 15) ? 14 : m_step + 1;
                    m_dir = (m_step != 15);
                end else begin
                    nstep = (m_step == 0) ? 1 : m_step - 1;
                    m_dir = (m_step == 0);
                end
`else
                wr = (m_step == 15) ? 1 : 0;
                nstep = (m_step + 1) % 16;
`endif
                push(m_seq, nstep, wr, 0, k + 3);
                m_step = nstep;
            end
            repeat (4) @(negedge clk_50);
            slow_clk = 1'b0;
            repeat (4) @(negedge clk_50);
        end
    endtask

    task automatic press(input bit up, input bit dn, input int hold);
        @(negedge clk_50);
        pb_seq_up = up;
        pb_seq_dn = dn;
        model_press(up, dn, cyc + 1);
        repeat (hold) @(negedge clk_50);
        pb_seq_up = 1'b0;
        pb_seq_dn = 1'b0;
        repeat (3) @(negedge clk_50);
    endtask

    // up edge lands on the same clk_50 edge as the synchronised tick
    task automatic tick_with_up(input int hold);
        int k;
        @(negedge clk_50);
        k = cyc;
        slow_clk = 1'b1;
        repeat (2) @(negedge clk_50);
        pb_seq_up = 1'b1;
        model_press(1'b1, 1'b0, k + 3);
        repeat (2) @(negedge clk_50);
        slow_clk = 1'b0;
        repeat (hold - 2) @(negedge clk_50);
        pb_seq_up = 1'b0;
        repeat (4) @(negedge clk_50);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete, %0d entries pending", q.size());
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk_50);
        chk("reset_rom_addr", int'(rom_addr), 0);
        chk("reset_seq_num", int'(seq_num), 0);
        chk("reset_step", int'(step), 0);
        chk("reset_wrap_pulse", int'(wrap_pulse), 0);
        chk("reset_seq_changed", int'(seq_changed), 0);
        reset = 1'b0;
        tick(3);
        chk("addr_after_three_ticks", int'(rom_addr), 2);
        tick(14);
`ifndef PATTERN_SEQ_BOUNCE_EN
        chk("wrap_rom_addr", int'(rom_addr), 0);
        chk("wrap_pulse_count", wrap_cnt, 1);
`endif
        press(1'b0, 1'b1, 5);
        chk("dn_wrap_seq_num", int'(seq_num), 63);
        chk("dn_wrap_rom_addr", int'(rom_addr), 1008);
        tick(1);
        chk("align_holds_addr", int'(rom_addr), 1008);
        tick(1);
        chk("first_step_addr", int'(rom_addr), 1009);
        for (int i = 0; i < 6; i++) press(1'b1, 1'b0, 3);
        chk("up_to_seq5", int'(seq_num), 5);
        tick(8);
        chk("seq5_step", int'(step), 7);
        chk("seq5_addr", int'(rom_addr), 87);
        tick_with_up(1000);
        chk("coincident_seq_num", int'(seq_num), 6);
        chk("coincident_rom_addr", int'(rom_addr), 96);
        chk("coincident_step", int'(step), 0);
        press(1'b1, 1'b1, 3);
        chk("both_buttons_seq_num", int'(seq_num), 6);
        tick(2);
        run_en = 1'b0;
        tick(5);
        chk("run_en_low_step", int'(step), 1);
        run_en = 1'b1;
        tick(1);
        chk("resume_step", int'(step), 2);
        chk("resume_addr", int'(rom_addr), 98);
        @(negedge clk_50);
        reset = 1'b1;
        m_seq = 0;
        m_step = 0;
        m_align = 1'b1;
        m_dir = 1'b1;
        #1;
        chk("midreset_rom_addr", int'(rom_addr), 0);
        chk("midreset_seq_num", int'(seq_num), 0);
        chk("midreset_step", int'(step), 0);
        @(negedge clk_50);
        reset = 1'b0;
        tick(1);
        chk("post_reset_align_addr", int'(rom_addr), 0);
        tick(1);
        chk("post_reset_step_addr", int'(rom_addr), 1);
`ifdef PATTERN_SEQ_BOUNCE_EN
        begin
            int w0;
            press(1'b1, 1'b0, 3);
            press(1'b1, 1'b0, 3);
            tick(1);
            w0 = wrap_cnt;
            tick(30);
            chk("bounce_return_addr", int'(rom_addr), 32);
            chk("bounce_wrap_count", wrap_cnt - w0, 1);
        end
`endif
        repeat (10) @(negedge clk_50);
        chk("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
